// File: rtl/cache_miss_handler.sv
// Per-CPU miss engine: optional dirty-victim writeback over the crossbar, then a
// bus Get (S or M), capture of the matching crossbar response, and a one-cycle
// fill pulse back to L1. A WAIT-state counter abandons requests that never get
// an answer and raises a sticky error.

package cache_miss_handler_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned CACHELINE_SIZE = 64;
    localparam int unsigned CPU_ID_W       = 2;

    typedef enum logic [1:0] {
        BusNone = 2'd0,
        BusGetS = 2'd1,
        BusGetM = 2'd2,
        BusUpgr = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic                valid;
        bus_tx_t             bus_tx;
        logic [XLEN-1:0]     addr;
        logic [CPU_ID_W-1:0] source;
    } bus_msg_t;

    typedef struct packed {
        logic                      valid;
        logic                      writeback;
        logic [XLEN-1:0]           addr;
        logic [CACHELINE_SIZE-1:0] data;
        logic [CPU_ID_W-1:0]       destination;
    } xbar_msg_t;

endpackage

module cache_miss_handler
    import cache_miss_handler_pkg::*;
#(
    parameter int unsigned CPU_ID         = 0,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    // L1 miss request
    input  logic                      miss_valid,
    output logic                      miss_ready,
    input  logic [XLEN-1:0]           miss_addr,
    input  logic                      miss_is_store,
    input  logic                      victim_dirty,
    input  logic [XLEN-1:0]           victim_addr,
    input  logic [CACHELINE_SIZE-1:0] victim_data,
    // Snooping bus
    output logic                      bus_req,
    input  logic                      bus_gnt,
    output bus_msg_t                  bus_out,
    // Crossbar to/from memory
    output xbar_msg_t                 xbar_out,
    input  xbar_msg_t                 xbar_in,
    // Fill back to L1
    output logic                      fill_valid,
    output logic [XLEN-1:0]           fill_addr,
    output logic [CACHELINE_SIZE-1:0] fill_data,
    output logic                      fill_is_modified,
    output logic                      timeout_err
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0]     CntMax = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CPU_ID_W-1:0] MyId   = CPU_ID_W'(CPU_ID);

    typedef enum logic [2:0] {
        StIdle,
        StWbArb,
        StArb,
        StWait,
        StFill
    } state_e;

    state_e                    state_q, state_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic                      is_store_q, is_store_d;
    logic [XLEN-1:0]           vaddr_q, vaddr_d;
    logic [CACHELINE_SIZE-1:0] vdata_q, vdata_d;
    logic [CACHELINE_SIZE-1:0] data_q, data_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      timeout_q, timeout_d;

    // Ungated outputs; the final assigns force everything low during reset.
    logic                      miss_ready_c;
    logic                      bus_req_c;
    bus_msg_t                  bus_out_c;
    xbar_msg_t                 xbar_out_c;
    logic                      fill_valid_c;
    logic                      resp_match;

    // A response counts only if it is a data reply for our latched line addressed to us.
    assign resp_match = xbar_in.valid && !xbar_in.writeback &&
                        (xbar_in.destination == MyId) && (xbar_in.addr == addr_q);

    // State and latched transaction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            is_store_q <= 1'b0;
            vaddr_q    <= '0;
            vdata_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            is_store_q <= is_store_d;
            vaddr_q    <= vaddr_d;
            vdata_q    <= vdata_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic and message generation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        is_store_d   = is_store_q;
        vaddr_d      = vaddr_q;
        vdata_d      = vdata_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        miss_ready_c = 1'b0;
        bus_req_c    = 1'b0;
        bus_out_c    = '0;
        xbar_out_c   = '0;
        fill_valid_c = 1'b0;

        unique case (state_q)
            StIdle: begin
                miss_ready_c = 1'b1;
                if (miss_valid) begin
                    addr_d     = miss_addr;
                    is_store_d = miss_is_store;
                    vaddr_d    = victim_addr;
                    vdata_d    = victim_data;
                    state_d    = victim_dirty ? StWbArb : StArb;
                end
            end

            StWbArb: begin
                bus_req_c = 1'b1;
                // The writeback goes out in its own grant cycle, ahead of the Get.
                if (bus_gnt) begin
                    xbar_out_c.valid       = 1'b1;
                    xbar_out_c.writeback   = 1'b1;
                    xbar_out_c.addr        = vaddr_q;
                    xbar_out_c.data        = vdata_q;
                    xbar_out_c.destination = '0;
                    state_d                = StArb;
                end
            end

            StArb: begin
                bus_req_c = 1'b1;
                if (bus_gnt) begin
                    bus_out_c.valid  = 1'b1;
                    bus_out_c.bus_tx = is_store_q ? BusGetM : BusGetS;
                    bus_out_c.addr   = addr_q;
                    bus_out_c.source = MyId;
                    // Memory may answer in the same cycle as the Get.
                    if (resp_match) begin
                        data_d  = xbar_in.data;
                        state_d = StFill;
                    end else begin
                        cnt_d   = '0;
                        state_d = StWait;
                    end
                end
            end

            StWait: begin
                // A match on the last allowed cycle still wins over the timeout.
                if (resp_match) begin
                    data_d  = xbar_in.data;
                    state_d = StFill;
                end else if (cnt_q == CntMax) begin
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StFill: begin
                fill_valid_c = 1'b1;
                state_d      = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign miss_ready       = miss_ready_c && !rst;
    assign bus_req          = bus_req_c && !rst;
    assign bus_out          = rst ? '0 : bus_out_c;
    assign xbar_out         = rst ? '0 : xbar_out_c;
    assign fill_valid       = fill_valid_c && !rst;
    assign fill_addr        = fill_valid ? addr_q : '0;
    assign fill_data        = fill_valid ? data_q : '0;
    assign fill_is_modified = fill_valid && is_store_q;
    assign timeout_err      = timeout_q && !rst;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: directed scenarios plus randomized
// misses. Each miss is described at transaction level (grant delays, response
// slot, noise) and the expected outputs follow from those parameters.

module tb_cache_miss_handler;
    import cache_miss_handler_pkg::*;

    localparam int unsigned CpuId = 1;
    localparam int unsigned To    = 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      miss_valid;
    logic                      miss_ready;
    logic [XLEN-1:0]           miss_addr;
    logic                      miss_is_store;
    logic                      victim_dirty;
    logic [XLEN-1:0]           victim_addr;
    logic [CACHELINE_SIZE-1:0] victim_data;
    logic                      bus_req;
    logic                      bus_gnt;
    bus_msg_t                  bus_out;
    xbar_msg_t                 xbar_out;
    xbar_msg_t                 xbar_in;
    logic                      fill_valid;
    logic [XLEN-1:0]           fill_addr;
    logic [CACHELINE_SIZE-1:0] fill_data;
    logic                      fill_is_modified;
    logic                      timeout_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        exp_err = 1'b0;

    cache_miss_handler #(
        .CPU_ID         (CpuId),
        .TIMEOUT_CYCLES (To)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_valid       (miss_valid),
        .miss_ready       (miss_ready),
        .miss_addr        (miss_addr),
        .miss_is_store    (miss_is_store),
        .victim_dirty     (victim_dirty),
        .victim_addr      (victim_addr),
        .victim_data      (victim_data),
        .bus_req          (bus_req),
        .bus_gnt          (bus_gnt),
        .bus_out          (bus_out),
        .xbar_out         (xbar_out),
        .xbar_in          (xbar_in),
        .fill_valid       (fill_valid),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data),
        .fill_is_modified (fill_is_modified),
        .timeout_err      (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bus_msg_t mk_get(input logic store, input logic [XLEN-1:0] a);
        bus_msg_t m;
        m        = '0;
        m.valid  = 1'b1;
        m.bus_tx = store ? BusGetM : BusGetS;
        m.addr   = a;
        m.source = CPU_ID_W'(CpuId);
        return m;
    endfunction

    function automatic xbar_msg_t mk_x(input logic wb, input logic [XLEN-1:0] a,
                                       input logic [CACHELINE_SIZE-1:0] d,
                                       input logic [CPU_ID_W-1:0] dst);
        xbar_msg_t m;
        m.valid       = 1'b1;
        m.writeback   = wb;
        m.addr        = a;
        m.data        = d;
        m.destination = dst;
        return m;
    endfunction

    function automatic logic [CACHELINE_SIZE-1:0] rnd_line();
        return {$urandom, $urandom};
    endfunction

    // One miss. resp_at: 0 = answer alongside the Get, 1..To = answer in that WAIT
    // cycle, > To = never answer (timeout expected).
    task automatic run_miss(input logic [XLEN-1:0] a, input logic store, input logic dirty,
                            input logic [XLEN-1:0] va, input logic [CACHELINE_SIZE-1:0] vd,
                            input logic [CACHELINE_SIZE-1:0] rd, input int wb_delay,
                            input int get_delay, input int resp_at, input logic noise);
        xbar_msg_t good;
        logic [CPU_ID_W-1:0] me;
        int j;
        me   = CPU_ID_W'(CpuId);
        good = mk_x(1'b0, a, rd, me);

        miss_valid    = 1'b1;
        miss_addr     = a;
        miss_is_store = store;
        victim_dirty  = dirty;
        victim_addr   = va;
        victim_data   = vd;
        bus_gnt       = 1'($urandom);
        xbar_in       = '0;
        @(negedge clk);
        check("idle_ready", 128'(miss_ready), 128'(1));
        check("idle_bus_quiet", 128'(bus_out), 128'(0));
        check("idle_xbar_quiet", 128'(xbar_out), 128'(0));
        next_cycle();
        miss_valid = 1'b0;
        miss_addr  = '1;

        if (dirty) begin
            for (int i = 0; i < wb_delay; i++) begin
                bus_gnt = 1'b0;
                @(negedge clk);
                check("wb_req", 128'(bus_req), 128'(1));
                check("wb_nogrant_xbar", 128'(xbar_out), 128'(0));
                next_cycle();
            end
            bus_gnt = 1'b1;
            @(negedge clk);
            check("wb_beat", 128'(xbar_out), 128'(mk_x(1'b1, va, vd, '0)));
            check("wb_no_get", 128'(bus_out), 128'(0));
            next_cycle();
        end

        for (int i = 0; i < get_delay; i++) begin
            bus_gnt = 1'b0;
            @(negedge clk);
            check("arb_req", 128'(bus_req), 128'(1));
            check("arb_nogrant_bus", 128'(bus_out), 128'(0));
            next_cycle();
        end
        bus_gnt = 1'b1;
        if (resp_at == 0) xbar_in = good;
        @(negedge clk);
        check("get_msg", 128'(bus_out), 128'(mk_get(store, a)));
        check("get_no_wb", 128'(xbar_out), 128'(0));
        next_cycle();
        bus_gnt = 1'b0;
        xbar_in = '0;

        if (resp_at != 0) begin
            j = 1;
            while (j <= To) begin
                bus_gnt = 1'($urandom);
                if (j == resp_at) xbar_in = good;
                else if (noise && j == resp_at - 1) xbar_in = mk_x(1'b0, a, rnd_line(), me + 1'b1);
                else if (noise && j == resp_at - 2) xbar_in = mk_x(1'b0, a ^ 32'h1, rnd_line(), me);
                else if (noise && j == resp_at - 3) xbar_in = mk_x(1'b1, a, rnd_line(), me);
                else xbar_in = '0;
                @(negedge clk);
                check("wait_req", 128'(bus_req), 128'(0));
                check("wait_bus_quiet", 128'(bus_out), 128'(0));
                check("wait_no_fill", 128'(fill_valid), 128'(0));
                next_cycle();
                if (j == resp_at) break;
                j++;
            end
            xbar_in = '0;
            bus_gnt = 1'b0;
        end

        if (resp_at <= To) begin
            @(negedge clk);
            check("fill_valid", 128'(fill_valid), 128'(1));
            check("fill_addr", 128'(fill_addr), 128'(a));
            check("fill_data", 128'(fill_data), 128'(rd));
            check("fill_mod", 128'(fill_is_modified), 128'(store));
            check("fill_err", 128'(timeout_err), 128'(exp_err));
            next_cycle();
        end else begin
            exp_err = 1'b1;
        end
        @(negedge clk);
        check("post_no_fill", 128'(fill_valid), 128'(0));
        check("post_ready", 128'(miss_ready), 128'(1));
        check("post_err", 128'(timeout_err), 128'(exp_err));
        next_cycle();
    endtask

    initial begin
        logic [CACHELINE_SIZE-1:0] d1;
        logic [CACHELINE_SIZE-1:0] d2;
        rst           = 1'b1;
        miss_valid    = 1'b0;
        miss_addr     = '0;
        miss_is_store = 1'b0;
        victim_dirty  = 1'b0;
        victim_addr   = '0;
        victim_data   = '0;
        bus_gnt       = 1'b1;
        xbar_in       = '0;
        next_cycle();
        @(negedge clk);
        check("rst_outputs", 128'(|{miss_ready, bus_req, bus_out, xbar_out, fill_valid,
                                   fill_addr, fill_data, fill_is_modified, timeout_err}), 128'(0));
        next_cycle();
        rst     = 1'b0;
        bus_gnt = 1'b0;

        // Clean load miss, immediate grant, same-cycle response.
        run_miss(32'h5, 1'b0, 1'b0, '0, '0, 64'h5, 0, 0, 0, 1'b0);
        // Store miss with dirty victim, grant delayed 3 cycles.
        run_miss(32'h3, 1'b1, 1'b1, 32'h9, 64'hAB, rnd_line(), 3, 0, 0, 1'b0);
        // Late response preceded by wrong-destination / wrong-address replies.
        run_miss(32'h40, 1'b0, 1'b0, '0, '0, rnd_line(), 0, 1, 5, 1'b1);
        // Response on the final WAIT cycle beats the timeout.
        run_miss(32'h44, 1'b1, 1'b0, '0, '0, rnd_line(), 0, 0, To, 1'b1);
        // No response: timeout, then a following miss still completes.
        run_miss(32'h48, 1'b0, 1'b1, 32'h77, rnd_line(), rnd_line(), 1, 2, To + 1, 1'b1);
        run_miss(32'h4C, 1'b0, 1'b0, '0, '0, rnd_line(), 0, 0, 2, 1'b0);

        // Reset during WAIT, then a late matching response.
        miss_valid = 1'b1;
        miss_addr  = 32'h60;
        miss_is_store = 1'b0;
        victim_dirty  = 1'b0;
        next_cycle();
        miss_valid = 1'b0;
        bus_gnt    = 1'b1;
        next_cycle();
        bus_gnt = 1'b0;
        next_cycle();
        next_cycle();
        rst     = 1'b1;
        bus_gnt = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_mid_outputs", 128'(|{miss_ready, bus_req, bus_out, xbar_out, fill_valid,
                                         fill_addr, fill_data, fill_is_modified, timeout_err}),
                  128'(0));
            next_cycle();
        end
        rst     = 1'b0;
        bus_gnt = 1'b0;
        exp_err = 1'b0;
        xbar_in = mk_x(1'b0, 32'h60, rnd_line(), CPU_ID_W'(CpuId));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_no_fill", 128'(fill_valid), 128'(0));
            check("late_ready", 128'(miss_ready), 128'(1));
            check("late_err_clear", 128'(timeout_err), 128'(0));
            next_cycle();
        end
        xbar_in = '0;

        // Back-to-back misses with miss_valid held high.
        d1 = rnd_line();
        d2 = rnd_line();
        miss_valid = 1'b1;
        miss_addr  = 32'h1;
        bus_gnt    = 1'b1;
        @(negedge clk);
        check("b2b_ready1", 128'(miss_ready), 128'(1));
        next_cycle();
        miss_addr = 32'h2;
        xbar_in   = mk_x(1'b0, 32'h1, d1, CPU_ID_W'(CpuId));
        @(negedge clk);
        check("b2b_busy_arb", 128'(miss_ready), 128'(0));
        check("b2b_get1", 128'(bus_out), 128'(mk_get(1'b0, 32'h1)));
        next_cycle();
        xbar_in = '0;
        @(negedge clk);
        check("b2b_busy_fill", 128'(miss_ready), 128'(0));
        check("b2b_fill1", 128'({fill_valid, fill_addr, fill_data}), 128'({1'b1, 32'h1, d1}));
        next_cycle();
        @(negedge clk);
        check("b2b_ready2", 128'(miss_ready), 128'(1));
        next_cycle();
        miss_valid = 1'b0;
        xbar_in    = mk_x(1'b0, 32'h2, d2, CPU_ID_W'(CpuId));
        @(negedge clk);
        check("b2b_get2", 128'(bus_out), 128'(mk_get(1'b0, 32'h2)));
        next_cycle();
        xbar_in = '0;
        bus_gnt = 1'b0;
        @(negedge clk);
        check("b2b_fill2", 128'({fill_valid, fill_addr, fill_data}), 128'({1'b1, 32'h2, d2}));
        next_cycle();

        // Randomized misses.
        for (int n = 0; n < 40; n++) begin
            int ra;
            ra = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, To + 1));
            run_miss($urandom, 1'($urandom), 1'($urandom), $urandom, rnd_line(), rnd_line(),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ra, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
